// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter that gives NUM_REQ requesters access to
// one SPI slave transmitter. The winner's word is latched into tx_din and
// tx_start is strobed for START_CYC cycles. The arbiter then waits for a
// synchronized rising edge of tx_qvld and pulses done to the winner.
// The optional macro SPI_TX_ARB_TIMEOUT_EN adds a WAIT timeout of TIMEOUT
// cycles. On a timeout, err is pulsed to the winner instead of done.
module spi_tx_arbiter #(
  parameter int DATA_LEN  = 8,
  parameter int NUM_REQ   = 4,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_LEN-1:0]  wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           err,
  output logic                         busy,
  output logic                         tx_en,
  output logic                         tx_start,
  output logic [DATA_LEN-1:0]          tx_din,
  input  logic                         tx_qvld
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, FIN} state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [IW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [SW-1:0]       start_cnt_reg, start_cnt_next;
  logic [DATA_LEN-1:0] tx_din_reg, tx_din_next;
  logic [1:0]          sync_reg;
  logic                qvld_d_reg;
  logic                compl_edge;
  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       idx_inc;

  // An out-of-range parameter set elaborates an empty marker block.
  if (TIMEOUT < 1 || NUM_REQ < 2 || NUM_REQ > 8 || START_CYC < 1) begin : g_bad_param
  end

`ifdef SPI_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          err_pulse_reg, err_pulse_next;
`endif

  // Two-flop synchronizer for tx_qvld, followed by an edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= 2'b00;
      qvld_d_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], tx_qvld};
      qvld_d_reg <= sync_reg[1];
    end
  end

  // Completion means a rising edge only. A level that is already high is ignored.
  assign compl_edge = sync_reg[1] & ~qvld_d_reg;

  // Round-robin search that starts at rr_ptr. The lowest offset wins, so the
  // loop runs from the highest offset down and the last hit is kept.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  // This is the requester after the current winner, with wrap-around.
  assign idx_inc = (idx_reg == IW'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      rr_ptr_reg    <= '0;
      start_cnt_reg <= '0;
      tx_din_reg    <= '0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
      err_pulse_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      start_cnt_reg <= start_cnt_next;
      tx_din_reg    <= tx_din_next;
`ifdef SPI_TX_ARB_TIMEOUT_EN
      tmo_cnt_reg   <= tmo_cnt_next;
      err_pulse_reg <= err_pulse_next;
`endif
    end
  end

  // Next-state logic. Once a grant is made, the index and word are frozen
  // until the transaction ends.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    start_cnt_next = '0;
    tx_din_next    = tx_din_reg;
`ifdef SPI_TX_ARB_TIMEOUT_EN
    tmo_cnt_next   = '0;
    err_pulse_next = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (pick_vld) begin
          idx_next    = pick_idx;
          tx_din_next = wdata[int'(pick_idx)*DATA_LEN +: DATA_LEN];
          state_next  = START;
        end
      end
      START: begin
        if (start_cnt_reg == SW'(START_CYC - 1)) begin
          state_next = WAIT;
        end else begin
          start_cnt_next = start_cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        // Completion is checked first, so it wins over a timeout in the same cycle.
        if (compl_edge) begin
          state_next  = FIN;
          rr_ptr_next = idx_inc;
        end
`ifdef SPI_TX_ARB_TIMEOUT_EN
        else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
          state_next     = IDLE;
          rr_ptr_next    = idx_inc;
          err_pulse_next = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end
      FIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode the one-hot outputs from the held winner index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign gnt[gi]  = ((state_reg == START) || (state_reg == WAIT)) && (idx_reg == IW'(gi));
    assign done[gi] = (state_reg == FIN) && (idx_reg == IW'(gi));
`ifdef SPI_TX_ARB_TIMEOUT_EN
    assign err[gi]  = err_pulse_reg && (idx_reg == IW'(gi));
`else
    assign err[gi]  = 1'b0;
`endif
  end

  assign busy     = (state_reg != IDLE);
  assign tx_start = (state_reg == START);
  assign tx_din   = tx_din_reg;
  assign tx_en    = rst_n;

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter DATA_LEN, 8, width of one transmit word.
REQ-002 Parameter NUM_REQ, 4, number of requesters (2..8).
REQ-003 Parameter START_CYC, 2, number of clk cycles tx_start is held high.
REQ-004 Parameter TIMEOUT, 4096, clk cycles allowed between end of tx_start and completion.
REQ-005 clk  input  1  single system clock; all logic on posedge clk.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  per-requester transmit request, level.
REQ-008 wdata  input  NUM_REQ*DATA_LEN  per-requester word; requester i occupies bits [i*DATA_LEN +: DATA_LEN].
REQ-009 gnt  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-010 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 err  output  NUM_REQ  one-cycle timeout pulse to the granted requester.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tx_en  output  1  enable to the SPI slave transmitter.
REQ-014 tx_start  output  1  load strobe to the SPI slave transmitter.
REQ-015 tx_din  output  DATA_LEN  word presented to the SPI slave transmitter.
REQ-016 tx_qvld  input  1  transmitter word-complete flag, asynchronous to clk.

Function
REQ-017 tx_qvld SHALL pass through a 2-flop synchronizer followed by an edge register; completion = synchronized 0->1 edge only; a level already high is not completion.
REQ-018 FSM states: IDLE, START, WAIT, FIN.
REQ-019 IDLE: if any req bit high, SHALL select requester by round-robin from pointer rr_ptr, set gnt one-hot, latch its wdata into tx_din, go START next cycle.
REQ-020 Round-robin: first requester with req high searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-021 START: tx_start SHALL be high for exactly START_CYC cycles, then WAIT; tx_din stable throughout.
REQ-022 WAIT: on completion edge go FIN; timeout counter increments each WAIT cycle.
REQ-023 FIN: done[granted]=1 for one cycle, gnt cleared, rr_ptr = granted index+1 (wrap to 0 after NUM_REQ-1), return to IDLE.
REQ-024 Latency: req high in IDLE at cycle N -> gnt/tx_din valid N+1, tx_start high N+1..N+START_CYC.
REQ-025 Requester dropping req after grant SHALL NOT abort the transaction; wdata changes after grant SHALL be ignored.
REQ-026 Completion edge outside WAIT SHALL be ignored.
REQ-027 Completion edge and timeout on the same cycle: completion wins.
REQ-028 tx_en SHALL be 1 whenever rst_n is high.
REQ-029 At most one gnt, done or err bit high in any cycle.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, gnt=0, done=0, err=0, busy=0, tx_en=0, tx_start=0, tx_din=0, rr_ptr=0, timeout counter=0, synchronizer flops=0.
REQ-031 Reset mid-transaction SHALL abandon it with no done/err pulse.

Configuration
REQ-032 Macro SPI_TX_ARB_TIMEOUT_EN defined: WAIT exits to IDLE after TIMEOUT cycles without completion, pulsing err[granted] one cycle, clearing gnt, advancing rr_ptr as in FIN.
REQ-033 Macro undefined: no timeout counter, WAIT held until completion, err tied to 0.

Verification
REQ-034 Reset: rst_n low mid-WAIT -> all outputs 0 same cycle, no done pulse after release.
REQ-035 Single request: req=4'b0100, wdata[23:16]=8'hA5 -> gnt=4'b0100, tx_din=8'hA5, tx_start high 2 cycles, tx_qvld 0->1 -> done=4'b0100 one cycle, busy low after.
REQ-036 Fairness: req=4'b1111 held, four completions -> grant order 0,1,2,3, then 0 again.
REQ-037 Stale flag: tx_qvld held high from before grant -> no done until it falls and rises again.
REQ-038 Timeout (macro defined, TIMEOUT=16): no tx_qvld edge -> err[granted] pulse 16 cycles after tx_start falls, next requester granted; macro undefined -> stays in WAIT, err=0.
REQ-039 Simultaneity: completion edge on the timeout cycle -> done pulse, no err.
